// File: rtl/bram_rd_arbiter_pkg.sv
// Shared defaults and helpers for the BRAM read-port arbiter.
//   DEF_* : default widths/depths for blk_mem_gen_0 (36 x 1024, two requesters)
//   clog2_min1 : index width that never collapses to zero bits
package bram_rd_arbiter_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 36;
  localparam int DEF_NUM_REQ   = 2;
  localparam int DEF_ID_W      = 1;
  localparam int DEF_RSP_DEPTH = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_rd_arbiter_if.sv
// Read request / response bundle between compute engines and the arbiter.
//   rd_valid/rd_addr/rd_ready : per-requester request handshake (addr packed, i at [i*ADDR_W +: ADDR_W])
//   rsp_valid/rsp_data/rsp_id/rsp_ready : single in-order tagged response stream
//   master : requester/consumer side, slave : arbiter side
interface bram_rd_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 36,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]        rd_valid;
  logic [NUM_REQ*ADDR_W-1:0] rd_addr;
  logic [NUM_REQ-1:0]        rd_ready;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_ready;

  modport master (
    output rd_valid, rd_addr, rsp_ready,
    input  rd_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  rd_valid, rd_addr, rsp_ready,
    output rd_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/bram_rd_arbiter_rr_arbiter.sv
// Round-robin arbiter.
//   clka, rst_n : clock, async active-low reset (pointer -> 0)
//   req         : request vector
//   advance     : a grant was taken this cycle; pointer moves past the winner
//   grant       : one-hot, first req at or after the pointer (combinational)
//   grant_idx   : binary index of grant (0 when no req)
module rr_arbiter
  import bram_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = clog2_min1(NUM_REQ)
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  // Scan starting at the pointer; idle requesters cost nothing.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance)
      ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;

endmodule

// File: rtl/bram_rd_arbiter.sv
// Shares BRAM port B among NUM_REQ readers, passes one writer to port A.
//   clka, rst_n        : single clock (also BRAM clka/clkb), async active-low reset
//   wr_valid/addr/data : write strobe, always accepted, forwarded straight to port A
//   rd_if (slave)      : round-robin read requests in, tagged in-order responses out
//   mem_wea/addra/dina : BRAM port A
//   mem_addrb          : BRAM port B address (granted address, else last one)
//   mem_doutb          : BRAM port B data, one cycle after addrb is sampled
// A read granted at edge T is captured into the RSP_DEPTH response FIFO at T+1.
// Grants are throttled so FIFO occupancy plus the read in flight never exceeds
// RSP_DEPTH, so consumer back-pressure can never drop BRAM data.
module bram_rd_arbiter
  import bram_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ID_W      = DEF_ID_W,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  bram_rd_arbiter_if.slave  rd_if,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  output logic [ADDR_W-1:0] mem_addrb,
  input  logic [DATA_W-1:0] mem_doutb
);

  localparam int IDX_W = clog2_min1(NUM_REQ);
  localparam int PTR_W = clog2_min1(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // write path
  assign mem_wea   = wr_valid;
  assign mem_addra = wr_addr;
  assign mem_dina  = wr_data;

  // state
  rsp_t              fifo_q [RSP_DEPTH];
  rsp_t              fifo_d [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  rsp_t              last_q, last_d;

  logic [NUM_REQ-1:0] grant, rd_ready;
  logic [IDX_W-1:0]   gidx;
  logic [ADDR_W-1:0]  gaddr;
  logic               rsp_valid, pop, slot, hs;
  rsp_t               push_ent;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clka      (clka),
    .rst_n     (rst_n),
    .req       (rd_if.rd_valid),
    .advance   (hs),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_comb begin
    rsp_valid = (occ_q != '0);
    pop       = rsp_valid & rd_if.rsp_ready;
    // A pop this cycle frees its slot in time for a grant this cycle.
    slot      = (int'(occ_q) + int'(inflight_q) - int'(pop)) < RSP_DEPTH;
    rd_ready  = (slot && rst_n) ? grant : '0;
    hs        = |(rd_if.rd_valid & rd_ready);
    gaddr     = rd_if.rd_addr[int'(gidx)*ADDR_W +: ADDR_W];

    addrb_d    = hs ? gaddr : addrb_q;
    inflight_d = hs;
    id_d       = hs ? ID_W'(gidx) : id_q;
    // BRAM returns old data on a same-edge write; remember the new data instead.
    fwd_d      = hs && wr_valid && (wr_addr == gaddr);
    fwd_data_d = wr_data;

    push_ent.id   = id_q;
    push_ent.data = fwd_q ? fwd_data_q : mem_doutb;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = push_ent;
      wr_ptr_d         = inc_ptr(wr_ptr_q);
    end
    if (pop) begin
      last_d   = fifo_q[rd_ptr_q];
      rd_ptr_d = inc_ptr(rd_ptr_q);
    end
    occ_d = occ_q + CNT_W'(inflight_q) - CNT_W'(pop);
  end

  assign mem_addrb = addrb_d;

  // While empty, the outputs show the last response popped (zero after reset).
  always_comb begin
    rd_if.rd_ready  = rd_ready;
    rd_if.rsp_valid = rsp_valid;
    rd_if.rsp_data  = rsp_valid ? fifo_q[rd_ptr_q].data : last_q.data;
    rd_if.rsp_id    = rsp_valid ? fifo_q[rd_ptr_q].id   : last_q.id;
  end

  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      id_q       <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      addrb_q    <= '0;
      last_q     <= '0;
    end else begin
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      id_q       <= id_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      addrb_q    <= addrb_d;
      last_q     <= last_d;
    end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
module tb_bram_rd_arbiter;
  localparam int AW = 10, DW = 36, N = 2, IW = 1, D = 2;

  logic          clka = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_wea;
  logic [AW-1:0] mem_addra, mem_addrb;
  logic [DW-1:0] mem_dina, mem_doutb;

  int vec = 0, err = 0;

  always #5 clka = ~clka;

  bram_rd_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) rif ();

  bram_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(N), .ID_W(IW), .RSP_DEPTH(D)) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_if     (rif),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_addrb (mem_addrb),
    .mem_doutb (mem_doutb)
  );

  // stand-in for blk_mem_gen_0: read-first, 1-cycle registered read
  logic [DW-1:0] bram [0:1023];
  always @(posedge clka) begin
    if (mem_wea) bram[mem_addra] <= mem_dina;
    mem_doutb <= bram[mem_addrb];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Every accepted read becomes an expected response, due two edges later,
  // leaving in acceptance order.
  typedef struct { logic [DW-1:0] d; int id; int rdy; } ent_t;
  ent_t          q[$];
  int            cyc = 0, ptr = 0, last_id = 0;
  logic [DW-1:0] shadow [0:1023];
  logic [DW-1:0] last_d = '0;
  logic [AW-1:0] last_addrb = '0;

  always @(negedge clka) begin
    logic       ev, pop, slot;
    int         gi, k;
    logic [N-1:0]  erdy;
    logic [AW-1:0] ga;
    ent_t       e;
    if (!rst_n) begin
      q.delete(); ptr = 0; last_d = '0; last_id = 0; last_addrb = '0;
      chk("rst_rd_ready", rif.rd_ready, 0);
      chk("rst_rsp_valid", rif.rsp_valid, 0);
      chk("rst_rsp_data", rif.rsp_data, 0);
      chk("rst_rsp_id", rif.rsp_id, 0);
      chk("rst_addrb", mem_addrb, 0);
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].rdy);
      chk("rsp_valid", rif.rsp_valid, ev);
      if (ev) begin
        chk("rsp_data", rif.rsp_data, q[0].d);
        chk("rsp_id", rif.rsp_id, q[0].id);
      end else begin
        chk("hold_data", rif.rsp_data, last_d);
        chk("hold_id", rif.rsp_id, last_id);
      end
      pop  = ev && rif.rsp_ready;
      slot = (q.size() - int'(pop)) < D;
      gi = -1;
      if (slot)
        for (k = 0; k < N; k++)
          if (gi < 0 && rif.rd_valid[(ptr + k) % N]) gi = (ptr + k) % N;
      erdy = '0;
      if (gi >= 0) erdy[gi] = 1'b1;
      chk("rd_ready", rif.rd_ready, erdy);
      if (pop) begin
        last_d = q[0].d; last_id = q[0].id; q.pop_front();
      end
      if (gi >= 0) begin
        ga    = rif.rd_addr[gi*AW +: AW];
        e.d   = (wr_valid && wr_addr == ga) ? wr_data : shadow[ga];
        e.id  = gi;
        e.rdy = cyc + 2;
        q.push_back(e);
        last_addrb = ga;
        ptr = (gi + 1) % N;
      end
      chk("mem_addrb", mem_addrb, last_addrb);
      if (wr_valid) shadow[wr_addr] = wr_data;
    end
    chk("pass_wea", mem_wea, wr_valid);
    chk("pass_addra", mem_addra, wr_addr);
    chk("pass_dina", mem_dina, wr_data);
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clka); #1;
  endtask

  task automatic get_rsp(output logic [DW-1:0] d, output int id);
    d = '0; id = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clka);
      if (rif.rsp_valid && rif.rsp_ready) begin
        d = rif.rsp_data; id = int'(rif.rsp_id);
        return;
      end
    end
    chk("rsp_timeout", 1, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int id, hs_cnt;
    logic [N-1:0] exp_g;
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rif.rd_valid = '0; rif.rd_addr = '0; rif.rsp_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // fill the address window used below
    for (int a = 0; a < 16; a++) begin
      wr_valid = 1'b1; wr_addr = AW'(a); wr_data = {4'($urandom), 32'($urandom)};
      step();
    end
    wr_valid = 1'b0;

    // mem[5]=A, mem[6]=B, then req0 reads 5, req1 reads 6
    wr_valid = 1'b1; wr_addr = 5; wr_data = 36'hA_AAAA_AAAA; step();
    wr_addr = 6; wr_data = 36'hB_BBBB_BBBB; step();
    wr_valid = 1'b0;
    rif.rd_valid = 2'b01; rif.rd_addr[0 +: AW] = 5; step();
    rif.rd_valid = 2'b10; rif.rd_addr[AW +: AW] = 6; step();
    rif.rd_valid = 2'b00;
    get_rsp(d, id); chk("pre_A_data", d, 36'hA_AAAA_AAAA); chk("pre_A_id", id, 0);
    get_rsp(d, id); chk("pre_B_data", d, 36'hB_BBBB_BBBB); chk("pre_B_id", id, 1);
    step();

    // same-cycle write/read of addr 9 forwards new data
    rif.rd_valid = 2'b01; rif.rd_addr[0 +: AW] = 9;
    wr_valid = 1'b1; wr_addr = 9; wr_data = 36'h123;
    step();
    rif.rd_valid = 2'b00; wr_valid = 1'b0;
    get_rsp(d, id); chk("fwd_new", d, 36'h123);
    step();
    // read one cycle before the write returns the old value
    rif.rd_valid = 2'b01; step();
    rif.rd_valid = 2'b00; wr_valid = 1'b1; wr_addr = 9; wr_data = 36'h456; step();
    wr_valid = 1'b0;
    get_rsp(d, id); chk("fwd_old", d, 36'h123);
    step();

    // only req1 valid: 4 grants in a row, then pointer favours req0
    rif.rd_valid = 2'b10; rif.rd_addr[AW +: AW] = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clka); chk("solo_req1", rif.rd_ready, 2'b10);
      @(posedge clka); #1;
    end
    rif.rd_valid = 2'b11; rif.rd_addr[0 +: AW] = 4;
    @(negedge clka); chk("solo_then_req0", rif.rd_ready, 2'b01);
    @(posedge clka); #1;

    // both stream: pointer now at 1, grants alternate
    for (int i = 0; i < 8; i++) begin
      rif.rd_addr[0 +: AW] = AW'($urandom_range(0, 15));
      rif.rd_addr[AW +: AW] = AW'($urandom_range(0, 15));
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clka); chk("alternate", rif.rd_ready, exp_g);
      @(posedge clka); #1;
    end
    rif.rd_valid = 2'b00;
    repeat (4) step();

    // back-pressure: exactly D grants, then none until a pop
    rif.rsp_ready = 1'b0; rif.rd_valid = 2'b11; hs_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clka); if (|(rif.rd_valid & rif.rd_ready)) hs_cnt++;
      @(posedge clka); #1;
    end
    chk("full_grants", hs_cnt, D);
    @(negedge clka); chk("full_no_ready", rif.rd_ready, 0);
    @(posedge clka); #1;
    rif.rsp_ready = 1'b1;
    @(negedge clka); chk("full_resume", |rif.rd_ready, 1);
    @(posedge clka); #1;
    rif.rd_valid = 2'b00;
    repeat (6) step();

    // reset with two queued responses
    rif.rsp_ready = 1'b0; rif.rd_valid = 2'b11;
    repeat (4) step();
    chk("pre_rst_full", rif.rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_now_valid", rif.rsp_valid, 0);
    chk("rst_now_ready", rif.rd_ready, 0);
    step();
    rst_n = 1'b1; rif.rd_valid = 2'b00; rif.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clka); chk("post_rst_silent", rif.rsp_valid, 0);
      @(posedge clka); #1;
    end

    // random traffic with one reset pulse
    for (int i = 0; i < 400; i++) begin
      rst_n         = (i != 200);
      rif.rd_valid  = N'($urandom);
      rif.rd_addr[0 +: AW]  = AW'($urandom_range(0, 15));
      rif.rd_addr[AW +: AW] = AW'($urandom_range(0, 15));
      wr_valid      = ($urandom_range(0, 2) == 0);
      wr_addr       = AW'($urandom_range(0, 15));
      wr_data       = {4'($urandom), 32'($urandom)};
      rif.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst_n = 1'b1; rif.rd_valid = '0; wr_valid = 1'b0; rif.rsp_ready = 1'b1;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
